// File: rtl/csidh_pkg.sv
// Shared constants and state encoding for the CSIDH host link.
package csidh_pkg;

  localparam int CSIDH_WORD        = 64;
  localparam int CSIDH_N           = 1024;
  localparam int CSIDH_A_CHUNKS    = CSIDH_N / CSIDH_WORD;
  localparam int CSIDH_PRIV_W      = 296;
  localparam int CSIDH_PRIV_CHUNKS = 6;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_LOAD = 2'd1;
  localparam logic [1:0] ST_WAIT = 2'd2;

  typedef enum logic [1:0] {
    IDLE = ST_IDLE,
    LOAD = ST_LOAD,
    WAIT = ST_WAIT
  } link_state_t;

endpackage

// File: rtl/csidh_link_rx_window.sv
// Receive window: collects 64-bit result chunks, oldest at the bottom, and
// offers the full N-bit result including the chunk arriving this cycle.
module csidh_link_rx_window
  import csidh_pkg::*;
#(
  parameter int N = CSIDH_N
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  shift_en,
  input  logic [CSIDH_WORD-1:0] link_rx,
  output logic [N-1:0]          assembled
);

  // Only the upper N-64 bits of the N-bit window survive a shift, so only
  // those are stored; the newest chunk comes straight from link_rx.
  logic [N-CSIDH_WORD-1:0] win_hi;

  always_ff @(posedge clk) begin
    if (rst) begin
      win_hi <= '0;
    end else if (shift_en) begin
      win_hi <= {link_rx, win_hi[N-CSIDH_WORD-1:CSIDH_WORD]};
    end
  end

  assign assembled = {link_rx, win_hi};

endmodule

// File: rtl/csidh_host_link.sv
// Host-side streaming master for the CSIDH top: serialises A and the private
// vector, then reassembles the result. Optional watchdog: CSIDH_LINK_TIMEOUT_EN.
module csidh_host_link
  import csidh_pkg::*;
#(
  parameter int N           = CSIDH_N,
  parameter int PRIV_W      = CSIDH_PRIV_W,
  parameter int PRIV_CHUNKS = CSIDH_PRIV_CHUNKS
`ifdef CSIDH_LINK_TIMEOUT_EN
  ,
  parameter logic [31:0] TIMEOUT_CYC = 32'hFFFF_FFFF
`endif
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [N-1:0]          a_in,
  input  logic [PRIV_W-1:0]     priv_in,
  output logic                  busy,
  output logic [N-1:0]          result,
  output logic                  result_valid,
`ifdef CSIDH_LINK_TIMEOUT_EN
  output logic                  timeout,
`endif
  output logic                  link_rst,
  output logic [CSIDH_WORD-1:0] link_tx,
  input  logic [CSIDH_WORD-1:0] link_rx,
  input  logic                  link_done
);

  localparam int A_CHUNKS   = N / CSIDH_WORD;
  localparam int TOTAL      = A_CHUNKS + PRIV_CHUNKS;
  localparam int TX_W       = TOTAL * CSIDH_WORD;
  localparam int PRIV_EXT_W = PRIV_CHUNKS * CSIDH_WORD;
  localparam int CNT_W      = $clog2(TOTAL + 1);

  link_state_t state, state_next;

  logic [CNT_W-1:0]         cnt;
  logic [TX_W-1:0]          tx_full;
  logic [TX_W-CSIDH_WORD-1:0] tx_sh;
  logic                     done_q;
  logic                     done_rise;
  logic                     load_last;
  logic                     wait_expired;
  logic                     rx_shift;
  logic [N-1:0]             rx_assembled;

  assign tx_full   = {PRIV_EXT_W'(priv_in), a_in};
  assign done_rise = link_done && !done_q;
  assign load_last = (cnt == CNT_W'(TOTAL));
  assign rx_shift  = (state == WAIT);

`ifdef CSIDH_LINK_TIMEOUT_EN
  logic [31:0] wait_cnt;
  assign wait_expired = (state == WAIT) && (wait_cnt == TIMEOUT_CYC - 32'd1);
`else
  assign wait_expired = 1'b0;
`endif

  csidh_link_rx_window #(
    .N(N)
  ) u_rx_window (
    .clk      (clk),
    .rst      (rst),
    .shift_en (rx_shift),
    .link_rx  (link_rx),
    .assembled(rx_assembled)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = LOAD;
      LOAD:    if (load_last) state_next = WAIT;
      WAIT:    if (done_rise || wait_expired) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // tx_sh holds the words still to be sent, next one at the bottom; cnt counts
  // words already on link_tx, so reaching TOTAL means the last one has had its cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt          <= '0;
      tx_sh        <= '0;
      link_tx      <= '0;
      link_rst     <= 1'b1;
      busy         <= 1'b0;
      result       <= '0;
      result_valid <= 1'b0;
      done_q       <= 1'b0;
`ifdef CSIDH_LINK_TIMEOUT_EN
      wait_cnt     <= '0;
      timeout      <= 1'b0;
`endif
    end else begin
      result_valid <= 1'b0;
      done_q       <= link_done;
`ifdef CSIDH_LINK_TIMEOUT_EN
      timeout      <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (start) begin
            tx_sh    <= tx_full[TX_W-1:CSIDH_WORD];
            link_tx  <= tx_full[CSIDH_WORD-1:0];
            cnt      <= CNT_W'(1);
            busy     <= 1'b1;
            link_rst <= 1'b0;
`ifdef CSIDH_LINK_TIMEOUT_EN
            wait_cnt <= '0;
`endif
          end
        end
        LOAD: begin
          if (load_last) begin
            link_tx <= '0;
          end else begin
            link_tx <= tx_sh[CSIDH_WORD-1:0];
            tx_sh   <= {{CSIDH_WORD{1'b0}}, tx_sh[TX_W-CSIDH_WORD-1:CSIDH_WORD]};
            cnt     <= cnt + CNT_W'(1);
          end
        end
        WAIT: begin
          if (done_rise) begin
            result       <= rx_assembled;
            result_valid <= 1'b1;
            link_rst     <= 1'b1;
            busy         <= 1'b0;
          end else if (wait_expired) begin
            link_rst <= 1'b1;
            busy     <= 1'b0;
`ifdef CSIDH_LINK_TIMEOUT_EN
            timeout  <= 1'b1;
`endif
          end
`ifdef CSIDH_LINK_TIMEOUT_EN
          wait_cnt <= wait_cnt + 32'd1;
`endif
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_csidh_host_link.sv
// Scoreboard bench for csidh_host_link: expected tx words and results are
// queued by the stimulus and checked by independent monitors.
module tb_csidh_host_link;

  localparam int N     = 1024;
  localparam int PW    = 296;
  localparam int TOTAL = 22;

  logic          clk;
  logic          rst;
  logic          start;
  logic [N-1:0]  a_in;
  logic [PW-1:0] priv_in;
  logic          busy;
  logic [N-1:0]  result;
  logic          result_valid;
  logic          link_rst;
  logic [63:0]   link_tx;
  logic [63:0]   link_rx;
  logic          link_done;
`ifdef CSIDH_LINK_TIMEOUT_EN
  logic          timeout;
`endif

  int total = 0;
  int bad   = 0;

  logic [63:0]  exp_tx[$];
  logic [N-1:0] exp_result[$];

`ifdef CSIDH_LINK_TIMEOUT_EN
  csidh_host_link #(
    .TIMEOUT_CYC(32'd100)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .a_in(a_in), .priv_in(priv_in),
    .busy(busy), .result(result), .result_valid(result_valid),
    .timeout(timeout), .link_rst(link_rst), .link_tx(link_tx),
    .link_rx(link_rx), .link_done(link_done)
  );
`else
  csidh_host_link dut (
    .clk(clk), .rst(rst), .start(start), .a_in(a_in), .priv_in(priv_in),
    .busy(busy), .result(result), .result_valid(result_valid),
    .link_rst(link_rst), .link_tx(link_tx),
    .link_rx(link_rx), .link_done(link_done)
  );
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_output(input string name, input logic [N-1:0] actual,
                              input logic [N-1:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
    end
  endtask

  // Tx monitor: while a burst is on the link, each word must match the queue
  // head; the cycle after the last word link_tx must return to zero.
  int tx_idx = 0;
  always @(negedge clk) begin
    if (!busy) begin
      tx_idx = 0;
    end else if (!link_rst && tx_idx < TOTAL) begin
      if (exp_tx.size() == 0) begin
        check_output("tx_unexpected_word", N'(link_tx), N'(0));
        if (link_tx == 64'h0) begin
          total++;
          bad++;
          $display("[TB] FAIL tx_unexpected_word: got word %0d expected none", tx_idx);
        end
      end else begin
        check_output($sformatf("tx_word%0d", tx_idx), N'(link_tx), N'(exp_tx.pop_front()));
      end
      tx_idx++;
    end else if (tx_idx == TOTAL) begin
      check_output("tx_zero_after_burst", N'(link_tx), N'(0));
      tx_idx++;
    end
  end

  // Result monitor: every result_valid pops one expectation; the following
  // cycle must show the pulse gone, the top back in reset and busy low.
  bit post_chk = 0;
  always @(negedge clk) begin
    if (post_chk) begin
      check_output("valid_one_cycle", N'(result_valid), N'(0));
      check_output("link_rst_after_done", N'(link_rst), N'(1));
      check_output("busy_after_done", N'(busy), N'(0));
      post_chk = 0;
    end
    if (result_valid) begin
      if (exp_result.size() == 0) begin
        total++;
        bad++;
        $display("[TB] FAIL unexpected_result_valid: got 1 expected 0");
      end else begin
        check_output("result", result, exp_result.pop_front());
      end
      post_chk = 1;
    end
  end

  task automatic apply_stimulus(input logic [N-1:0] a, input logic [PW-1:0] p);
    a_in    = a;
    priv_in = p;
    start   = 1'b1;
    @(negedge clk);
    start   = 1'b0;
  endtask

  task automatic stream_result(input logic [63:0] base);
    for (int k = 0; k < 16; k++) begin
      link_rx   = base + 64'(k);
      link_done = (k == 15);
      @(negedge clk);
    end
    link_rx   = '0;
    link_done = 1'b0;
  endtask

  task automatic wait_result(input string name, input int budget);
    int n;
    n = 0;
    while (!result_valid && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (!result_valid) begin
      total++;
      bad++;
      $display("[TB] FAIL %s: got no result_valid within %0d cycles expected pulse", name, budget);
    end
  endtask

  logic [N-1:0] a_val;
  logic [N-1:0] r_val;
  logic [PW-1:0] p_val;

  initial begin
    rst = 1'b1; start = 1'b0; a_in = '0; priv_in = '0;
    link_rx = '0; link_done = 1'b0;
    repeat (3) @(negedge clk);
    check_output("reset_busy", N'(busy), N'(0));
    check_output("reset_result", result, N'(0));
    check_output("reset_valid", N'(result_valid), N'(0));
    check_output("reset_link_rst", N'(link_rst), N'(1));
    check_output("reset_link_tx", N'(link_tx), N'(0));
    rst = 1'b0;
    @(negedge clk);

    // Test 1: A=1, priv=0; stub returns chunks 0..F.
    exp_tx.push_back(64'h1);
    for (int i = 1; i < TOTAL; i++) exp_tx.push_back(64'h0);
    r_val = '0;
    for (int k = 0; k < 16; k++) r_val[k*64 +: 64] = 64'(k);
    exp_result.push_back(r_val);
    apply_stimulus(N'(1), '0);
    check_output("word0_link_tx", N'(link_tx), N'(1));
    check_output("word0_link_rst", N'(link_rst), N'(0));
    check_output("word0_busy", N'(busy), N'(1));
    repeat (28) @(negedge clk);
    stream_result(64'h0);
    wait_result("t1_result", 20);
    repeat (3) @(negedge clk);

    // Test 2: patterned A, priv bit 295, done high on WAIT entry, stray starts.
    a_val = '0;
    for (int i = 0; i < 16; i++) begin
      a_val[i*64 +: 64] = 64'h1111_0000_0000_0000 + 64'(i);
      exp_tx.push_back(64'h1111_0000_0000_0000 + 64'(i));
    end
    exp_tx.push_back(64'h0); exp_tx.push_back(64'h0);
    exp_tx.push_back(64'h0); exp_tx.push_back(64'h0);
    exp_tx.push_back(64'h0000_0080_0000_0000);
    exp_tx.push_back(64'h0);
    p_val = '0;
    p_val[295] = 1'b1;
    r_val = '0;
    for (int k = 0; k < 16; k++) r_val[k*64 +: 64] = 64'hC0DE_0000_0000_0000 + 64'(k);
    exp_result.push_back(r_val);
    link_done = 1'b1;
    apply_stimulus(a_val, p_val);
    repeat (4) @(negedge clk);
    start = 1'b1; a_in = '1; priv_in = '1;
    @(negedge clk);
    start = 1'b0;
    repeat (22) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    stream_result(64'hC0DE_0000_0000_0000);
    wait_result("t2_result", 20);

    // Test 3: restart the cycle after result_valid, then reset at word 10.
    @(negedge clk);
    a_val = '0;
    for (int i = 0; i < 16; i++) begin
      a_val[i*64 +: 64] = 64'h3300 + 64'(i);
      exp_tx.push_back(64'h3300 + 64'(i));
    end
    for (int i = 16; i < TOTAL; i++) exp_tx.push_back(64'h0);
    apply_stimulus(a_val, '0);
    for (int n = 0; n < 40 && !(busy && link_tx == 64'h330A); n++) @(negedge clk);
    check_output("t3_reached_word10", N'(link_tx), N'(64'h330A));
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_output("midrst_link_rst", N'(link_rst), N'(1));
    check_output("midrst_busy", N'(busy), N'(0));
    check_output("midrst_link_tx", N'(link_tx), N'(0));
    check_output("midrst_result", result, N'(0));
    check_output("midrst_valid", N'(result_valid), N'(0));
    exp_tx.delete();
    repeat (30) @(negedge clk);
    check_output("midrst_idle_busy", N'(busy), N'(0));

`ifdef CSIDH_LINK_TIMEOUT_EN
    // Watchdog: link_done held low, abort 100 cycles after WAIT entry.
    exp_tx.push_back(64'h1);
    for (int i = 1; i < TOTAL; i++) exp_tx.push_back(64'h0);
    apply_stimulus(N'(1), '0);
    for (int k = 1; k <= 123; k++) begin
      @(negedge clk);
      if (k == 121) check_output("timeout_early", N'(timeout), N'(0));
      if (k == 122) begin
        check_output("timeout_pulse", N'(timeout), N'(1));
        check_output("timeout_busy", N'(busy), N'(0));
        check_output("timeout_link_rst", N'(link_rst), N'(1));
        check_output("timeout_result", result, N'(0));
      end
      if (k == 123) check_output("timeout_one_cycle", N'(timeout), N'(0));
    end
`endif

    repeat (5) @(negedge clk);
    check_output("leftover_tx_expect", N'(exp_tx.size()), N'(0));
    check_output("leftover_result_expect", N'(exp_result.size()), N'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: got no finish expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
